// File: rtl/irq_pend_pkg.sv
// Shared types and helpers for the 16-line pending/select front end.
package irq_pend_pkg;

    localparam int N_LINES = 16;
    localparam int ID_W    = 4;

    typedef logic [N_LINES-1:0] line_vec_t;
    typedef logic [ID_W-1:0]    line_id_t;

    // Output register state: EMPTY means nothing presented, HOLD means an ID is offered.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

    function automatic line_vec_t onehot16(input line_id_t id);
        line_vec_t v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_sel16.sv
// Combinational highest-index-wins selector over 16 candidate lines.
module prio_sel16
    import irq_pend_pkg::*;
(
    input  line_vec_t cand,
    output line_id_t  sel,
    output logic      any
);

    // Scan upward so the last (highest) set bit is the one that sticks.
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int i = 0; i < N_LINES; i++) begin
            if (cand[i]) begin
                sel = line_id_t'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pend_sel16.sv
// Edge-capturing pending register with priority select and a registered
// valid/ready output. Optional lost-edge tracking is enabled by defining
// IRQ_PEND_OVF_EN, which adds the ovf output and ovf_clr input.
module irq_pend_sel16
    import irq_pend_pkg::*;
#(
    parameter  int N   = N_LINES,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic           en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IDW-1:0] out_id,
    output logic           idle
`ifdef IRQ_PEND_OVF_EN
    ,
    output logic [N-1:0]   ovf,
    input  logic [N-1:0]   ovf_clr
`endif
);

    logic [N-1:0]   req_d;
    logic [N-1:0]   pending;
    logic [N-1:0]   rise;
    logic [N-1:0]   clr;
    logic [N-1:0]   pending_next;
    logic [N-1:0]   cand;
    line_id_t       sel;
    logic           any;
    out_state_t     state;
    out_state_t     state_next;
    logic [IDW-1:0] out_id_next;

    assign out_valid = (state == ST_HOLD);

    // Edge detect, served-line clear, pending update and selection candidates.
    always_comb begin
        rise         = req & ~req_d;
        clr          = (state == ST_HOLD && out_ready) ? onehot16(out_id) : '0;
        pending_next = (pending & ~clr) | (rise & mask);
        cand         = pending & mask & ~clr;
    end

    prio_sel16 u_sel (
        .cand (cand),
        .sel  (sel),
        .any  (any)
    );

    // Request history, pending bits and the idle flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_d   <= '0;
            pending <= '0;
            idle    <= 1'b0;
        end else begin
            req_d   <= req;
            pending <= pending_next;
            idle    <= en & ~|(pending_next & mask);
        end
    end

    // Output presentation: load when empty, hold until accepted, reload on accept.
    always_comb begin
        state_next  = state;
        out_id_next = out_id;
        case (state)
            ST_EMPTY: begin
                if (en && any) begin
                    state_next  = ST_HOLD;
                    out_id_next = sel;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_id_next = sel;
                    state_next  = (en && any) ? ST_HOLD : ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Output state register; reset drops any offer without acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            out_id <= '0;
        end else begin
            state  <= state_next;
            out_id <= out_id_next;
        end
    end

`ifdef IRQ_PEND_OVF_EN
    // Sticky lost-edge flags; a new loss beats a simultaneous software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | (rise & mask & pending & ~clr);
        end
    end
`endif

endmodule

// File: tb/tb_irq_pend_sel16.sv
// Self-checking bench for irq_pend_sel16 with a behavioural reference model.
module tb_irq_pend_sel16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] mask;
    logic        en;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic        idle;
`ifdef IRQ_PEND_OVF_EN
    logic [15:0] ovf;
    logic [15:0] ovf_clr;
    bit   [15:0] m_ovf, n_ovf;
`endif

    int tests = 0;
    int fails = 0;

    bit [15:0] m_pend, n_pend;
    bit [15:0] m_prev, n_prev;
    bit        m_valid, n_valid;
    int        m_id, n_id;
    bit        m_idle, n_idle;

    always #5 clk = ~clk;

    irq_pend_sel16 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .en        (en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .idle      (idle)
`ifdef IRQ_PEND_OVF_EN
        ,
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`endif
    );

    // Reference: derive next-cycle outputs from the current inputs and model state.
    task automatic computeNext();
        bit [15:0] rise;
        bit [15:0] clrv;
        int        best;
        rise = req & ~m_prev;
        clrv = '0;
        if (m_valid && out_ready) clrv[m_id] = 1'b1;
        best = -1;
        for (int i = 0; i < 16; i++) begin
            n_pend[i] = (m_pend[i] & ~clrv[i]) | (rise[i] & mask[i]);
            if (m_pend[i] && mask[i] && !clrv[i]) best = i;
`ifdef IRQ_PEND_OVF_EN
            n_ovf[i] = (m_ovf[i] & ~ovf_clr[i]) | (rise[i] & mask[i] & m_pend[i] & ~clrv[i]);
`endif
        end
        n_prev = req;
        if (!m_valid) begin
            n_valid = en && (best >= 0);
            n_id    = n_valid ? best : m_id;
        end else if (out_ready) begin
            n_valid = en && (best >= 0);
            n_id    = (best >= 0) ? best : 0;
        end else begin
            n_valid = 1'b1;
            n_id    = m_id;
        end
        n_idle = en && ((n_pend & mask) == 16'h0);
        if (rst) begin
            n_pend  = '0;
            n_prev  = '0;
            n_valid = 1'b0;
            n_id    = 0;
            n_idle  = 1'b0;
`ifdef IRQ_PEND_OVF_EN
            n_ovf   = '0;
`endif
        end
    endtask

    task automatic checkOutput();
        tests++;
        if (out_valid !== m_valid) begin
            fails++;
            $display("[TB] FAIL out_valid @%0t: got %b want %b", $time, out_valid, m_valid);
        end
        tests++;
        if (idle !== m_idle) begin
            fails++;
            $display("[TB] FAIL idle @%0t: got %b want %b", $time, idle, m_idle);
        end
        if (m_valid) begin
            tests++;
            if (int'(out_id) != m_id || $isunknown(out_id)) begin
                fails++;
                $display("[TB] FAIL out_id @%0t: got %0d want %0d", $time, out_id, m_id);
            end
        end
`ifdef IRQ_PEND_OVF_EN
        tests++;
        if (ovf !== m_ovf) begin
            fails++;
            $display("[TB] FAIL ovf @%0t: got %h want %h", $time, ovf, m_ovf);
        end
`endif
    endtask

    task automatic checkLiteral(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got %0d want %0d", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and compare after the edge.
    task automatic applyStimulus(input bit rst_v, input bit [15:0] req_v, input bit [15:0] mask_v,
                                 input bit en_v, input bit ready_v);
        rst       = rst_v;
        req       = req_v;
        mask      = mask_v;
        en        = en_v;
        out_ready = ready_v;
        @(negedge clk);
        computeNext();
        @(posedge clk);
        #1;
        m_pend  = n_pend;
        m_prev  = n_prev;
        m_valid = n_valid;
        m_id    = n_id;
        m_idle  = n_idle;
`ifdef IRQ_PEND_OVF_EN
        m_ovf   = n_ovf;
`endif
        checkOutput();
    endtask

    int exp_ids[4] = '{15, 10, 5, 0};

    initial begin
        rst = 1'b1; req = '0; mask = 16'hFFFF; en = 1'b1; out_ready = 1'b0;
`ifdef IRQ_PEND_OVF_EN
        ovf_clr = '0;
        m_ovf   = '0;
`endif
        m_pend = '0; m_prev = '0; m_valid = 1'b0; m_id = 0; m_idle = 1'b0;
        @(posedge clk);
        #1;

        // Reset then a single request on line 5
        applyStimulus(1, 16'h0000, 16'hFFFF, 1, 1);
        applyStimulus(1, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("reset_valid", int'(out_valid), 0);
        checkLiteral("reset_idle", int'(idle), 0);
        applyStimulus(0, 16'h0020, 16'hFFFF, 1, 1);
        checkLiteral("single_pending_wait", int'(out_valid), 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("single_valid", int'(out_valid), 1);
        checkLiteral("single_id", int'(out_id), 5);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("single_done_valid", int'(out_valid), 0);
        checkLiteral("single_done_idle", int'(idle), 1);

        // Priority order and back-to-back service
        applyStimulus(0, 16'h8421, 16'hFFFF, 1, 1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
            checkLiteral("b2b_valid", int'(out_valid), 1);
            checkLiteral("b2b_id", int'(out_id), exp_ids[k]);
        end
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("b2b_end_valid", int'(out_valid), 0);

        // Hold stability: no preemption by line 12
        applyStimulus(0, 16'h0008, 16'hFFFF, 1, 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 0);
        checkLiteral("hold_first_id", int'(out_id), 3);
        applyStimulus(0, 16'h1000, 16'hFFFF, 1, 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 0);
        checkLiteral("hold_still_id", int'(out_id), 3);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("hold_next_id", int'(out_id), 12);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("hold_end_valid", int'(out_valid), 0);

        // Set wins over clear on line 7
        applyStimulus(0, 16'h0080, 16'hFFFF, 1, 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 0);
        checkLiteral("soc_first_id", int'(out_id), 7);
        applyStimulus(0, 16'h0080, 16'hFFFF, 1, 1);
        checkLiteral("soc_gap_valid", int'(out_valid), 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("soc_again_valid", int'(out_valid), 1);
        checkLiteral("soc_again_id", int'(out_id), 7);
`ifdef IRQ_PEND_OVF_EN
        checkLiteral("soc_ovf7", int'(ovf[7]), 0);
`endif
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);

        // Mask blocks capture; en gates presentation
        applyStimulus(0, 16'h0200, 16'hFDFF, 1, 1);
        applyStimulus(0, 16'h0000, 16'hFDFF, 1, 1);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("mask_valid", int'(out_valid), 0);
        checkLiteral("mask_idle", int'(idle), 1);
        applyStimulus(0, 16'h0010, 16'hFFFF, 0, 1);
        applyStimulus(0, 16'h0000, 16'hFFFF, 0, 1);
        applyStimulus(0, 16'h0000, 16'hFFFF, 0, 1);
        checkLiteral("en_off_valid", int'(out_valid), 0);
        checkLiteral("en_off_idle", int'(idle), 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 0);
        checkLiteral("en_on_valid", int'(out_valid), 1);
        checkLiteral("en_on_id", int'(out_id), 4);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);

        // Reset mid-operation drops the offer and the pending bits
        applyStimulus(0, 16'h0C00, 16'hFFFF, 1, 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 0);
        checkLiteral("midrst_pre_id", int'(out_id), 11);
        applyStimulus(1, 16'h0000, 16'hFFFF, 1, 0);
        checkLiteral("midrst_valid", int'(out_valid), 0);
        checkLiteral("midrst_id", int'(out_id), 0);
        checkLiteral("midrst_idle", int'(idle), 0);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);
        checkLiteral("midrst_quiet", int'(out_valid), 0);

        // Line held high through reset re-captures as a rise
        applyStimulus(0, 16'h0040, 16'hFFFF, 1, 0);
        applyStimulus(1, 16'h0040, 16'hFFFF, 1, 0);
        applyStimulus(0, 16'h0040, 16'hFFFF, 1, 0);
        applyStimulus(0, 16'h0040, 16'hFFFF, 1, 0);
        checkLiteral("recap_id", int'(out_id), 6);
        applyStimulus(0, 16'h0000, 16'hFFFF, 1, 1);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            bit [15:0] r_req, r_mask;
            r_req  = 16'($urandom) & 16'($urandom);
            r_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
`ifdef IRQ_PEND_OVF_EN
            ovf_clr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
`endif
            applyStimulus($urandom_range(0, 99) == 0, r_req, r_mask,
                          $urandom_range(0, 5) != 0, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
